// File: rtl/pulpemu_input_cond.sv
// Input conditioner: synchronise, debounce and edge-detect the raw switch/button pins.
// Define PULPEMU_INPUT_EVENT_EN to build the sticky event flags and irq_o summary.

module pulpemu_input_cond_bit #(
    parameter int SYNC_STAGES    = 2,
    parameter int STABLE_SAMPLES = 4,
    parameter int CW             = $clog2(STABLE_SAMPLES) + 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic tick,
    input  logic raw,
    output logic level,
    output logic rise,
    output logic fall
);
    logic [SYNC_STAGES-1:0] sync_q;
    logic [CW-1:0]          cnt;
    logic                   sync;

    assign sync = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sync_q <= '0;
        else        sync_q <= {sync_q[SYNC_STAGES-2:0], raw};
    end

    // Any cycle where the input agrees with the accepted level restarts qualification.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt   <= '0;
            level <= 1'b0;
            rise  <= 1'b0;
            fall  <= 1'b0;
        end else begin
            rise <= 1'b0;
            fall <= 1'b0;
            if (sync == level) begin
                cnt <= '0;
            end else if (tick) begin
                if (cnt == CW'(STABLE_SAMPLES - 1)) begin
                    level <= sync;
                    cnt   <= '0;
                    rise  <= sync;
                    fall  <= ~sync;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end
    end
endmodule

module pulpemu_input_cond #(
    parameter int N_IN           = 13,
    parameter int SYNC_STAGES    = 2,
    parameter int PRESCALE       = 20000,
    parameter int STABLE_SAMPLES = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N_IN-1:0] raw_i,
    output logic [N_IN-1:0] level_o,
    output logic [N_IN-1:0] rise_o,
    output logic [N_IN-1:0] fall_o,
    output logic [N_IN-1:0] event_o,
    input  logic [N_IN-1:0] event_clr_i,
    output logic            irq_o
);
    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    logic tick;

    generate
        if (PRESCALE == 1) begin : g_no_pre
            assign tick = 1'b1;
        end else begin : g_pre
            logic [PW-1:0] pre;
            assign tick = (pre == PW'(PRESCALE - 1));
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n)    pre <= '0;
                else if (tick) pre <= '0;
                else           pre <= pre + 1'b1;
            end
        end
    endgenerate

    pulpemu_input_cond_bit #(
        .SYNC_STAGES   (SYNC_STAGES),
        .STABLE_SAMPLES(STABLE_SAMPLES)
    ) u_bit [N_IN-1:0] (
        .clk  (clk),
        .rst_n(rst_n),
        .tick (tick),
        .raw  (raw_i),
        .level(level_o),
        .rise (rise_o),
        .fall (fall_o)
    );

`ifdef PULPEMU_INPUT_EVENT_EN
    logic [N_IN-1:0] event_q;

    // A new edge outranks a clear landing in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) event_q <= '0;
        else        event_q <= (event_q & ~event_clr_i) | rise_o | fall_o;
    end

    assign event_o = event_q;
    assign irq_o   = |event_q;
`else
    logic unused_event_clr;
    assign unused_event_clr = ^event_clr_i;
    assign event_o = '0;
    assign irq_o   = 1'b0;
`endif
endmodule

// File: tb/tb_pulpemu_input_cond.sv
// Directed bench for pulpemu_input_cond with PRESCALE=4, STABLE_SAMPLES=3, SYNC_STAGES=2.
module tb_pulpemu_input_cond;
    localparam int N = 13;
`ifdef PULPEMU_INPUT_EVENT_EN
    localparam logic EV = 1'b1;
`else
    localparam logic EV = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [N-1:0] raw_i = '0;
    logic [N-1:0] event_clr_i = '0;
    logic [N-1:0] level_o, rise_o, fall_o, event_o;
    logic         irq_o;

    int total = 0;
    int bad   = 0;

    pulpemu_input_cond #(
        .N_IN(N), .SYNC_STAGES(2), .PRESCALE(4), .STABLE_SAMPLES(3)
    ) dut (
        .clk(clk), .rst_n(rst_n), .raw_i(raw_i), .level_o(level_o),
        .rise_o(rise_o), .fall_o(fall_o), .event_o(event_o),
        .event_clr_i(event_clr_i), .irq_o(irq_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        int idx;
        int hi;
        int exp_edges;
    } vec_t;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_range(input string name, input int n, input int lo, input int hi);
        total++;
        if (n < lo || n > hi) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d..%0d", name, n, lo, hi);
        end
    endtask

    // Edges until rise_o[b] pulses; 0 if it never does within the budget.
    task automatic wait_rise(input int b, output int n);
        n = 0;
        for (int k = 1; k <= 40 && n == 0; k++) begin
            step();
            if (rise_o[b]) n = k;
        end
    endtask

    initial begin
        vec_t         tv[6];
        logic [N-1:0] m, prev;
        int           n, nr, nf, other, irq_seen;

        tv[0] = '{8, 5, 0};
        tv[1] = '{6, 1, 0};
        tv[2] = '{7, 3, 0};
        tv[3] = '{9, 8, 0};
        tv[4] = '{10, 12, 1};
        tv[5] = '{11, 20, 1};

        step();
        step();
        chk("reset_level", 32'(level_o), 0);
        chk("reset_pulses", 32'(rise_o | fall_o), 0);
        chk("reset_event", {31'd0, irq_o} | 32'(event_o), 0);
        rst_n = 1'b1;
        step();

        // Table: a high pulse of 'hi' cycles, then low for 40 cycles.
        for (int t = 0; t < 6; t++) begin
            m = '0;
            m[tv[t].idx] = 1'b1;
            nr = 0; nf = 0; other = 0;
            for (int c = 0; c < tv[t].hi + 40; c++) begin
                raw_i[tv[t].idx] = (c < tv[t].hi);
                step();
                if (rise_o[tv[t].idx]) nr++;
                if (fall_o[tv[t].idx]) nf++;
                if (((rise_o | fall_o) & ~m) != 0) other++;
            end
            chk($sformatf("tbl%0d_rise", t), nr, tv[t].exp_edges);
            chk($sformatf("tbl%0d_fall", t), nf, tv[t].exp_edges);
            chk($sformatf("tbl%0d_level", t), 32'(level_o), 0);
            chk($sformatf("tbl%0d_other", t), other, 0);
        end

        // Clean step on bit 0.
        prev = level_o;
        raw_i[0] = 1'b1;
        n = 0;
        for (int k = 1; k <= 40 && n == 0; k++) begin
            step();
            if (level_o[0]) n = k;
        end
        chk_range("step_latency", n, 11, 14);
        chk("step_rise_coincident", 32'(rise_o[0]), 1);
        chk("step_no_fall", 32'(fall_o[0]), 0);
        chk("step_others", 32'(level_o & ~13'd1), 32'(prev));
        step();
        chk("step_rise_one_cycle", 32'(rise_o[0]), 0);

        // Bounce on bit 3: 6 high, 2 low, then held high.
        nr = 0;
        for (int c = 0; c < 8; c++) begin
            raw_i[3] = (c < 6);
            step();
            if (rise_o[3]) nr++;
        end
        chk("bounce_no_early", nr, 0);
        raw_i[3] = 1'b1;
        wait_rise(3, n);
        chk_range("bounce_latency", n, 11, 14);
        nr = 0;
        for (int c = 0; c < 30; c++) begin
            step();
            if (rise_o[3]) nr++;
        end
        chk("bounce_single_pulse", nr, 0);

        // Falling edge on bit 12 with event flag and clear.
        raw_i[12] = 1'b1;
        wait_rise(12, n);
        chk_range("b12_rise_latency", n, 11, 14);
        step();
        event_clr_i = '1;
        step();
        event_clr_i = '0;
        chk("clear_all_irq", 32'(irq_o), 0);
        raw_i[12] = 1'b0;
        n = 0;
        for (int k = 1; k <= 40 && n == 0; k++) begin
            step();
            if (fall_o[12]) n = k;
        end
        chk_range("fall_latency", n, 11, 14);
        chk("fall_level", 32'(level_o[12]), 0);
        chk("fall_event_pre", 32'(event_o[12]), 0);
        step();
        chk("fall_event_set", 32'(event_o[12]), 32'(EV));
        chk("fall_irq_set", 32'(irq_o), 32'(EV));
        event_clr_i[12] = 1'b1;
        step();
        event_clr_i[12] = 1'b0;
        chk("fall_event_clr", 32'(event_o[12]), 0);
        chk("fall_irq_clr", 32'(irq_o), 0);

        // Set/clear collision on bit 5.
        raw_i[5] = 1'b1;
        wait_rise(5, n);
        chk_range("coll_latency", n, 11, 14);
        event_clr_i[5] = 1'b1;
        step();
        event_clr_i[5] = 1'b0;
        chk("coll_set_wins", 32'(event_o[5]), 32'(EV));
        step();
        chk("coll_sticky", 32'(event_o[5]), 32'(EV));

        // Reset mid-qualification on bit 1.
        raw_i[1] = 1'b1;
        repeat (8) step();
        rst_n = 1'b0;
        #1;
        chk("rst_level", 32'(level_o), 0);
        chk("rst_pulses", 32'(rise_o | fall_o), 0);
        chk("rst_event", {31'd0, irq_o} | 32'(event_o), 0);
        step();
        step();
        chk("rst_hold_level", 32'(level_o), 0);
        rst_n = 1'b1;
        n = 0;
        irq_seen = 0;
        for (int k = 1; k <= 40 && n == 0; k++) begin
            step();
            if (irq_o) irq_seen++;
            if (rise_o[1]) n = k;
        end
        chk_range("rst_rise_latency", n, 11, 14);
        chk("rst_level_bit1", 32'(level_o[1]), 1);
        if (!EV) chk("irq_never", irq_seen, 0);
        else     chk("irq_after_rst_rise", 32'(irq_o), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
